sigmoid_lut_loader: RTL and testbench

SIGMOID_LUT_LOADER -- requirements
Module: sigmoid_lut_loader

---
 rtl/sigmoid_lut_loader.sv | 109 ++++++++++
 tb/tb_sigmoid_lut_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_lut_loader.sv
// Sigmoid lookup table: streamed full-table loader plus single-cycle lookups.
// The table may only be read once a complete, unaborted load has landed.
module sigmoid_lut_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_load_start,
  input  logic              io_load_abort,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_data,
  input  logic              io_rd_en,
  input  logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_dataOut,
  output logic              io_rd_valid,
  output logic              io_busy,
  output logic              io_load_done,
  output logic              io_table_valid,
  output logic [ADDR_W:0]   io_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic in_load;
  logic wr_fire;
  logic wr_last;
  logic rd_fire;

  assign in_load = (state == LOAD);
  assign wr_fire = in_load && io_in_valid && !io_load_abort;
  assign wr_last = (waddr == LAST_ADDR);
  assign rd_fire = io_rd_en && (state == IDLE) && io_table_valid;

  assign io_in_ready = in_load;
  assign io_busy     = in_load;

  // Storage is deliberately left out of reset; io_table_valid guards it.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[waddr] <= io_in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      waddr          <= '0;
      io_count       <= '0;
      io_load_done   <= 1'b0;
      io_table_valid <= 1'b0;
      io_rd_valid    <= 1'b0;
      io_dataOut     <= '0;
    end else begin
      io_rd_valid <= rd_fire;
      if (rd_fire) begin
        io_dataOut <= mem[io_addr];
      end
      unique case (state)
        IDLE: begin
          io_load_done <= 1'b0;
          if (io_load_start) begin
            state          <= LOAD;
            waddr          <= '0;
            io_count       <= '0;
            io_table_valid <= 1'b0;
          end
        end
        LOAD: begin
          if (io_load_abort) begin
            state <= IDLE;
          end else if (io_in_valid) begin
            waddr <= waddr + 1'b1;
            if (io_count != FULL_CNT) begin
              io_count <= io_count + 1'b1;
            end
            if (wr_last) begin
              state          <= DONE;
              io_load_done   <= 1'b1;
              io_table_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          io_load_done <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          io_load_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_lut_loader.sv
// Randomized bench for sigmoid_lut_loader with a lookup scoreboard.
// Stimulus pushes expected lookup results; a monitor pops and compares.
module tb_sigmoid_lut_loader;

  logic        clock;
  logic        reset;
  logic        io_load_start;
  logic        io_load_abort;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [9:0]  io_in_data;
  logic        io_rd_en;
  logic [9:0]  io_addr;
  logic [9:0]  io_dataOut;
  logic        io_rd_valid;
  logic        io_busy;
  logic        io_load_done;
  logic        io_table_valid;
  logic [10:0] io_count;

  sigmoid_lut_loader dut (
    .clock         (clock),
    .reset         (reset),
    .io_load_start (io_load_start),
    .io_load_abort (io_load_abort),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_data    (io_in_data),
    .io_rd_en      (io_rd_en),
    .io_addr       (io_addr),
    .io_dataOut    (io_dataOut),
    .io_rd_valid   (io_rd_valid),
    .io_busy       (io_busy),
    .io_load_done  (io_load_done),
    .io_table_valid(io_table_valid),
    .io_count      (io_count)
  );

  typedef struct {
    int         cyc;
    bit         vld;
    logic [9:0] d;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         done_seen = 0;
  logic [9:0] last_d = '0;

  // reference model: table contents, words accepted, table usable
  logic [9:0] model_mem [1024];
  int         wk = 0;
  bit         model_ok = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    bit   want;
    cyc++;
    #1;
    if (!reset) begin
      last_d = '0;
      q.delete();
    end else begin
      if (io_load_done) done_seen++;
      want = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        want = e.vld;
        if (e.vld) chk("rd_data", io_dataOut, e.d);
      end
      chk("rd_valid", io_rd_valid, want);
      if (io_rd_valid) last_d = io_dataOut;
      else chk("data_hold", io_dataOut, last_d);
    end
  end

  task automatic lookup(input logic [9:0] a);
    exp_t e;
    io_rd_en = 1'b1;
    io_addr  = a;
    e.cyc = cyc + 1;
    e.vld = model_ok;
    e.d   = model_mem[a];
    q.push_back(e);
    @(negedge clock);
  endtask

  task automatic begin_load();
    io_load_start = 1'b1;
    @(negedge clock);
    io_load_start = 1'b0;
    wk = 0;
    model_ok = 0;
    chk("start_busy", io_busy, 1);
    chk("start_count", io_count, 0);
    chk("start_tv", io_table_valid, 0);
  endtask

  task automatic put_word(input logic [9:0] d, input bit abort,
                          input bit extra);
    exp_t e;
    while ($urandom_range(0, 3) == 0) begin
      io_in_valid = 1'b0;
      io_in_data  = 10'($urandom);
      @(negedge clock);
    end
    chk("in_ready", io_in_ready, 1);
    io_in_valid   = 1'b1;
    io_in_data    = d;
    io_load_abort = abort;
    if (extra) begin
      io_rd_en      = 1'b1;
      io_addr       = 10'($urandom);
      io_load_start = 1'b1;
      e.cyc = cyc + 1;
      e.vld = 0;
      e.d   = '0;
      q.push_back(e);
    end
    @(negedge clock);
    io_in_valid   = 1'b0;
    io_load_abort = 1'b0;
    io_rd_en      = 1'b0;
    io_load_start = 1'b0;
    if (!abort) begin
      model_mem[wk] = d;
      wk++;
    end
    chk("count", io_count, wk);
  endtask

  task automatic stream(input int n, input int mode);
    logic [9:0] d;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       d = 10'(wk);
        1:       d = ~10'(wk);
        default: d = 10'($urandom);
      endcase
      put_word(d, 1'b0, (wk % 97) == 13 && wk < 1000);
    end
  endtask

  task automatic finish_load();
    exp_t e;
    chk("done_pulse", io_load_done, 1);
    chk("done_tv", io_table_valid, 1);
    chk("done_ready", io_in_ready, 0);
    chk("done_busy", io_busy, 0);
    chk("done_count", io_count, 1024);
    io_load_start = 1'b1;
    io_load_abort = 1'b1;
    io_in_valid   = 1'b1;
    io_rd_en      = 1'b1;
    io_addr       = 10'd5;
    e.cyc = cyc + 1;
    e.vld = 0;
    e.d   = '0;
    q.push_back(e);
    @(negedge clock);
    io_load_start = 1'b0;
    io_load_abort = 1'b0;
    io_in_valid   = 1'b0;
    io_rd_en      = 1'b0;
    model_ok = 1;
    chk("post_done_pulse", io_load_done, 0);
    chk("post_done_busy", io_busy, 0);
    chk("post_done_tv", io_table_valid, 1);
    chk("post_done_count", io_count, 1024);
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) lookup(10'($urandom));
    io_rd_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    io_load_start = 0;
    io_load_abort = 0;
    io_in_valid = 0;
    io_in_data = '0;
    io_rd_en = 0;
    io_addr = '0;
    repeat (2) @(negedge clock);
    chk("rst_ready", io_in_ready, 0);
    chk("rst_busy", io_busy, 0);
    chk("rst_done", io_load_done, 0);
    chk("rst_tv", io_table_valid, 0);
    chk("rst_count", io_count, 0);
    chk("rst_rdv", io_rd_valid, 0);
    chk("rst_data", io_dataOut, 0);
    reset = 1'b1;
    @(negedge clock);

    // no table yet: lookups refused
    lookup(10'd3);
    io_rd_en = 1'b0;
    @(negedge clock);

    // full load with data k, then boundary and random lookups
    begin_load();
    stream(1024, 0);
    finish_load();
    lookup(10'd0);
    lookup(10'd511);
    lookup(10'd1023);
    io_rd_en = 1'b0;
    @(negedge clock);
    rand_reads(300);
    @(negedge clock);

    // abort after 300 words with a word on the bus
    begin_load();
    stream(300, 2);
    put_word(10'($urandom), 1'b1, 1'b0);
    chk("abort_busy", io_busy, 0);
    chk("abort_count", io_count, 300);
    chk("abort_tv", io_table_valid, 0);
    chk("abort_ready", io_in_ready, 0);
    lookup(10'd7);
    io_rd_en = 1'b0;
    io_load_abort = 1'b1;
    @(negedge clock);
    io_load_abort = 1'b0;
    chk("idle_abort_busy", io_busy, 0);

    // abort coincident with the final handshake
    begin_load();
    stream(1023, 2);
    put_word(10'($urandom), 1'b1, 1'b0);
    chk("abort_last_done", io_load_done, 0);
    chk("abort_last_tv", io_table_valid, 0);
    chk("abort_last_count", io_count, 1023);
    chk("abort_last_busy", io_busy, 0);
    rand_reads(4);

    // reset mid-load at word 500, then a fresh full load
    begin_load();
    stream(500, 2);
    io_in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", io_in_ready, 0);
    chk("mid_rst_busy", io_busy, 0);
    chk("mid_rst_done", io_load_done, 0);
    chk("mid_rst_tv", io_table_valid, 0);
    chk("mid_rst_count", io_count, 0);
    chk("mid_rst_rdv", io_rd_valid, 0);
    chk("mid_rst_data", io_dataOut, 0);
    @(negedge clock);
    io_in_valid = 1'b0;
    reset = 1'b1;
    model_ok = 0;
    @(negedge clock);
    chk("rst_idle_busy", io_busy, 0);
    begin_load();
    stream(1024, 1);
    finish_load();
    lookup(10'd0);
    lookup(10'd1023);
    io_rd_en = 1'b0;
    rand_reads(200);

    repeat (3) @(negedge clock);
    chk("queue_empty", q.size(), 0);
    chk("done_pulses", done_seen, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
